// File: rtl/regfile_wr_decode.sv
`default_nettype none
// ============================================================================
// Module   : regfile_wr_decode
// Purpose  : 32x32 RISC-V integer register file with a 1-to-32 write decoder,
//            a post-reset clear sequencer and two combinational read ports.
//            Optional same-cycle write-to-read bypass: REGFILE_BYPASS_EN.
// Revision : 1.0
// ============================================================================
module regfile_wr_decode #(
  parameter int XLEN = 32,
  parameter int NREG = 32,
  parameter int AW   = 5
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            wr_valid,
  output logic            wr_ready,
  input  logic [AW-1:0]   wr_addr,
  input  logic [XLEN-1:0] wr_data,
  input  logic [AW-1:0]   rs1_addr,
  output logic [XLEN-1:0] rs1_data,
  input  logic [AW-1:0]   rs2_addr,
  output logic [XLEN-1:0] rs2_data,
  output logic            init_done
);

  typedef enum logic [0:0] {
    ST_INIT = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  state_t          state_q;
  logic [AW-1:0]   clr_cnt_q;
  logic            wr_ready_q;
  logic            init_done_q;

  logic            w_run;
  logic            w_accept;
  logic            w_dec_en;
  logic [AW-1:0]   w_dec_addr;
  logic [XLEN-1:0] w_wr_data;
  logic [NREG-1:1] w_wr_en;
  logic [XLEN-1:0] w_rs1;
  logic [XLEN-1:0] w_rs2;

  // x0 has no storage; index 0 is handled by the read mux default.
  logic [XLEN-1:0] regs_q [1:NREG-1];

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_INIT;
      clr_cnt_q   <= AW'(1);
      wr_ready_q  <= 1'b0;
      init_done_q <= 1'b0;
    end else begin
      case (state_q)
        ST_INIT: begin
          clr_cnt_q <= clr_cnt_q + AW'(1);
          if (clr_cnt_q == AW'(NREG-1)) begin
            state_q     <= ST_RUN;
            wr_ready_q  <= 1'b1;
            init_done_q <= 1'b1;
          end
        end
        ST_RUN: begin
          state_q     <= ST_RUN;
          wr_ready_q  <= 1'b1;
          init_done_q <= 1'b1;
        end
        default: begin
          state_q     <= ST_INIT;
          clr_cnt_q   <= AW'(1);
          wr_ready_q  <= 1'b0;
          init_done_q <= 1'b0;
        end
      endcase
    end
  end

  // A reset arriving mid-RUN blanks the outputs in its own cycle, so a write
  // presented alongside it never completes the handshake.
  assign w_run     = wr_ready_q & ~rst;
  assign wr_ready  = w_run;
  assign init_done = init_done_q & ~rst;
  assign w_accept  = wr_valid & w_run;

  // The clear sequencer and write-back share the decoder.
  assign w_dec_en   = w_accept | ((state_q == ST_INIT) & ~rst);
  assign w_dec_addr = w_run ? wr_addr : clr_cnt_q;
  assign w_wr_data  = w_run ? wr_data : '0;

  generate
    for (genvar gi = 1; gi < NREG; gi++) begin : g_dec
      assign w_wr_en[gi] = w_dec_en & (w_dec_addr == AW'(gi));
    end
  endgenerate

  always_ff @(posedge clk) begin
    for (int i = 1; i < NREG; i++) begin
      if (w_wr_en[i]) begin
        regs_q[i] <= w_wr_data;
      end
    end
  end

  always_comb begin
    w_rs1 = '0;
    w_rs2 = '0;
    for (int i = 1; i < NREG; i++) begin
      if (rs1_addr == AW'(i)) w_rs1 = regs_q[i];
      if (rs2_addr == AW'(i)) w_rs2 = regs_q[i];
    end
`ifdef REGFILE_BYPASS_EN
    if (w_accept && (wr_addr != '0) && (wr_addr == rs1_addr)) w_rs1 = wr_data;
    if (w_accept && (wr_addr != '0) && (wr_addr == rs2_addr)) w_rs2 = wr_data;
`else
`endif
    if (!w_run) begin
      w_rs1 = '0;
      w_rs2 = '0;
    end
  end

  assign rs1_data = w_rs1;
  assign rs2_data = w_rs2;

endmodule
`default_nettype wire

// File: tb/tb_regfile_wr_decode.sv
`default_nettype none
// ============================================================================
// Module   : tb_regfile_wr_decode
// Purpose  : Directed plus random bench for regfile_wr_decode against an
//            array-based reference model.
// Revision : 1.0
// ============================================================================
module tb_regfile_wr_decode;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        wr_valid = 1'b0;
  logic        wr_ready;
  logic [4:0]  wr_addr = '0;
  logic [31:0] wr_data = '0;
  logic [4:0]  rs1_addr = '0;
  logic [31:0] rs1_data;
  logic [4:0]  rs2_addr = '0;
  logic [31:0] rs2_data;
  logic        init_done;

  int n_cmp = 0;
  int n_bad = 0;

  logic [31:0] m_reg [32];
  int          m_n = 0;

  always #5 clk = ~clk;

  regfile_wr_decode dut (
    .clk       (clk),
    .rst       (rst),
    .wr_valid  (wr_valid),
    .wr_ready  (wr_ready),
    .wr_addr   (wr_addr),
    .wr_data   (wr_data),
    .rs1_addr  (rs1_addr),
    .rs1_data  (rs1_data),
    .rs2_addr  (rs2_addr),
    .rs2_data  (rs2_data),
    .init_done (init_done)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Reference read value: x0 is zero, nothing readable outside RUN.
  function automatic logic [31:0] exp_rd(input bit run, input bit v, input logic [4:0] wa,
                                         input logic [31:0] wd, input logic [4:0] a);
    if (!run || a == 5'd0) return 32'd0;
`ifdef REGFILE_BYPASS_EN
    if (v && wa != 5'd0 && wa == a) return wd;
`else
    if (v && wa == 5'd31 && wd == 32'd0 && a == 5'd0) return 32'd0;
`endif
    return m_reg[a];
  endfunction

  // One cycle: drive inputs, check at negedge, advance model at posedge.
  task automatic step(input bit r, input bit v, input logic [4:0] wa, input logic [31:0] wd,
                      input logic [4:0] a1, input logic [4:0] a2);
    bit run;
    rst = r; wr_valid = v; wr_addr = wa; wr_data = wd; rs1_addr = a1; rs2_addr = a2;
    @(negedge clk);
    run = !r && (m_n >= 31);
    chk("wr_ready",  {31'd0, wr_ready},  {31'd0, run});
    chk("init_done", {31'd0, init_done}, {31'd0, run});
    chk($sformatf("rs1_data[x%0d]", a1), rs1_data, exp_rd(run, v, wa, wd, a1));
    chk($sformatf("rs2_data[x%0d]", a2), rs2_data, exp_rd(run, v, wa, wd, a2));
    @(posedge clk);
    if (r) begin
      m_n = 0;
    end else begin
      if (run && v && wa != 5'd0) m_reg[wa] = wd;
      m_n++;
      if (m_n == 31) foreach (m_reg[i]) m_reg[i] = 32'd0;
    end
    #1;
  endtask

  initial begin
    foreach (m_reg[i]) m_reg[i] = 32'd0;

    // Reset for two cycles, then the 31-cycle clear with writes attempted.
    step(1'b1, 1'b1, 5'd4, 32'hAAAA_0000, 5'd5, 5'd31);
    step(1'b1, 1'b1, 5'd4, 32'hAAAA_0001, 5'd5, 5'd31);
    for (int i = 0; i < 31; i++) step(1'b0, 1'b1, 5'd5, $urandom, 5'd5, 5'd31);
    step(1'b0, 1'b0, 5'd0, 32'd0, 5'd5, 5'd31);

    // Basic write/read.
    step(1'b0, 1'b1, 5'd7, 32'hDEAD_BEEF, 5'd7, 5'd8);
    step(1'b0, 1'b0, 5'd0, 32'd0, 5'd7, 5'd8);

    // x0 is never written.
    step(1'b0, 1'b1, 5'd0, 32'hFFFF_FFFF, 5'd0, 5'd0);
    step(1'b0, 1'b0, 5'd0, 32'd0, 5'd0, 5'd0);

    // Back-to-back writes then a full sweep for one-hot decode.
    for (int i = 1; i < 32; i++) step(1'b0, 1'b1, 5'(i), 32'(i), 5'd0, 5'(i));
    for (int i = 0; i < 32; i++) step(1'b0, 1'b0, 5'd0, 32'd0, 5'(i), 5'(31 - i));

    // Mid-run reset; writes during the clear are ignored.
    step(1'b1, 1'b1, 5'd3, 32'h55, 5'd3, 5'd3);
    for (int i = 0; i < 31; i++) step(1'b0, 1'b1, 5'd3, 32'h55, 5'd3, 5'(i));
    for (int i = 0; i < 32; i++) step(1'b0, 1'b0, 5'd0, 32'd0, 5'(i), 5'd3);

    // Same-cycle write and read of x9.
    step(1'b0, 1'b1, 5'd9, 32'h1234, 5'd9, 5'd9);
    step(1'b0, 1'b0, 5'd0, 32'd0, 5'd9, 5'd10);

    // Random traffic with occasional resets.
    for (int i = 0; i < 400; i++) begin
      step(($urandom_range(0, 99) == 0), 1'($urandom_range(0, 1)), 5'($urandom_range(0, 31)),
           $urandom, 5'($urandom_range(0, 31)), 5'($urandom_range(0, 31)));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/regfile_wr_decode.md
Name: regfile_wr_decode

Overview:
- 32-entry x 32-bit integer register file for the RISC-V core, built around a write-side 1-to-32 decoder (demux).
- The decoder is the write-end counterpart of the 32-to-1 read-select path.
- Accepts write-back through a valid/ready handshake and serves two combinational read ports.
- After reset, a sequencer clears every register one per cycle; writes are held off until clearing completes.

Parameters:
- XLEN, 32, data width of each register and of every data port.
- NREG, 32, number of architectural registers; x0 is hardwired to zero.
- AW, 5, address width; must equal log2(NREG).

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- rst  input  1  reset, synchronous, active-high.
- wr_valid  input  1  write-back request valid.
- wr_ready  output  1  register file can accept a write this cycle.
- wr_addr  input  AW  destination register index.
- wr_data  input  XLEN  write-back data.
- rs1_addr  input  AW  read port 1 index.
- rs1_data  output  XLEN  read port 1 data, combinational.
- rs2_addr  input  AW  read port 2 index.
- rs2_data  output  XLEN  read port 2 data, combinational.
- init_done  output  1  high once the clear sequence has finished.

Behaviour:
- Storage: registers 1..NREG-1 are flops; x0 has no storage and always reads 0.
- FSM states: INIT and RUN.
- Clear counter: clr_cnt, width AW.
- While rst is high: state <= INIT, clr_cnt <= 1.
  - Outputs during reset: wr_ready=0, init_done=0, rs1_data=0, rs2_data=0.
  - Register contents are don't-care while rst is high.
- INIT, each cycle:
  - reg[clr_cnt] <= 0.
  - clr_cnt increments.
  - When clr_cnt==NREG-1, the next state is RUN.
- INIT duration: exactly NREG-1 = 31 cycles after rst deasserts. init_done is first high in cycle 32.
- INIT outputs: wr_ready=0, init_done=0, read data forced to 0. wr_valid is ignored; nothing is latched.
- RUN outputs: wr_ready=1, init_done=1.
- Write accept: a write is accepted when wr_valid && wr_ready at a rising edge.
  - The decoder asserts exactly one enable, for wr_addr.
  - reg[wr_addr] <= wr_data.
- wr_addr==0 in RUN: the write is accepted (handshake completes) but has no effect.
- Write latency: the new value is visible on the read ports the cycle after acceptance.
  - Without the bypass, a same-cycle read returns the old value.
- Reads in RUN: rsN_data = (rsN_addr==0) ? 0 : reg[rsN_addr], purely combinational.
  - Both ports are independent and may read the same index.
- rst asserted mid-INIT or mid-RUN: takes effect at the next edge.
  - Any write presented in that cycle is dropped.
  - The sequencer restarts from clr_cnt=1.
- No X propagation: read data is defined in all states.

Optional Feature:
- Macro: REGFILE_BYPASS_EN.
- Defined: a write-to-read bypass is added.
  - In RUN, if an accepted write has wr_addr!=0 and wr_addr==rsN_addr, rsN_data = wr_data in the same cycle (this covers a decode-stage read in the same cycle as write-back).
  - Port 1 and port 2 bypass independently.
  - There is no bypass during INIT.
- Undefined: no bypass; same-cycle reads return the pre-write value.

Test Plan:
- Reset then init timing: pulse rst for 2 cycles, then release.
  - wr_ready=0 and init_done=0 for exactly 31 cycles.
  - Both go to 1 in cycle 32.
  - rs1_addr=5 and rs2_addr=31 read 0 throughout.
- Basic write/read: write x7=0xDEADBEEF.
  - Next cycle rs1_addr=7 reads 0xDEADBEEF.
  - rs2_addr=8 reads 0.
- x0 protection: write x0=0xFFFFFFFF.
  - wr_ready=1 (handshake completes).
  - Next cycle rs1_addr=0 and rs2_addr=0 read 0x00000000.
- Back-to-back writes: write x1=1, x2=2, ..., x31=31 on consecutive cycles.
  - Sweeping rs1_addr 0..31 returns the value equal to the index.
  - No neighbouring register is corrupted (one-hot decode check).
- Mid-operation reset and INIT blocking: fill registers, assert rst for 1 cycle, drive wr_valid=1 with x3=0x55 during INIT.
  - The INIT write is ignored.
  - After init_done, x3 reads 0 and all registers read 0.
- Same-cycle read/write: write x9=0x1234 while rs1_addr=9.
  - REGFILE_BYPASS_EN defined: same cycle reads 0x1234.
  - REGFILE_BYPASS_EN undefined: same cycle reads the old value 0; next cycle reads 0x1234.
